// File: rtl/mouse_master_sm.sv
// PS/2 mouse sequencer: power-up handshake (reset, self-test, ID, enable) then 3-byte packet parsing.
// Optional watchdog on wait states is built only when MOUSE_WATCHDOG_EN is defined.
module mouse_master_sm #(
    parameter int STARTUP_CYCLES = 5_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] MASTER_STATE
);

    localparam int CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STARTUP_TC = CNT_W'(STARTUP_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_STARTUP       = 4'd0,
        ST_SEND_RST      = 4'd1,
        ST_WAIT_SENT_RST = 4'd2,
        ST_WAIT_ACK1     = 4'd3,
        ST_WAIT_SELFTEST = 4'd4,
        ST_WAIT_ID       = 4'd5,
        ST_SEND_EN       = 4'd6,
        ST_WAIT_SENT_EN  = 4'd7,
        ST_WAIT_ACK2     = 4'd8,
        ST_RX_STATUS     = 4'd9,
        ST_RX_DX         = 4'd10,
        ST_RX_DY         = 4'd11,
        ST_IRQ           = 4'd12
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow_status;
    logic [7:0]       shadow_dx;
    logic [7:0]       shadow_dy;
    logic [7:0]       expect_byte;
    state_t           init_next;
    logic             rx_err;
    logic             wd_expire;

    assign rx_err = (BYTE_ERROR_CODE != 2'b00);

`ifdef MOUSE_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    assign wd_expire = (cnt == TIMEOUT_TC);
`else
    assign wd_expire = 1'b0;
`endif

    // Expected reply and successor for the four handshake receive states.
    always_comb begin
        expect_byte = 8'hFA;
        init_next   = ST_STARTUP;
        case (state)
            ST_WAIT_ACK1:     begin expect_byte = 8'hFA; init_next = ST_WAIT_SELFTEST; end
            ST_WAIT_SELFTEST: begin expect_byte = 8'hAA; init_next = ST_WAIT_ID;       end
            ST_WAIT_ID:       begin expect_byte = 8'h00; init_next = ST_SEND_EN;       end
            ST_WAIT_ACK2:     begin expect_byte = 8'hFA; init_next = ST_RX_STATUS;     end
            default:          begin expect_byte = 8'hFA; init_next = ST_STARTUP;       end
        endcase
    end

    assign MASTER_STATE = state;
    assign READ_ENABLE  = (state == ST_WAIT_ACK1) || (state == ST_WAIT_SELFTEST) ||
                          (state == ST_WAIT_ID)   || (state == ST_WAIT_ACK2)     ||
                          (state == ST_RX_STATUS) || (state == ST_RX_DX)         ||
                          (state == ST_RX_DY);

    // Every state change also clears cnt, so the startup and watchdog timers restart per state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_STARTUP;
            cnt            <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'h00;
            SEND_INTERRUPT <= 1'b0;
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
            shadow_status  <= 8'h00;
            shadow_dx      <= 8'h00;
            shadow_dy      <= 8'h00;
        end else begin
            SEND_BYTE      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            cnt            <= cnt + 1'b1;
            case (state)
                ST_STARTUP: begin
                    if (cnt == STARTUP_TC) begin state <= ST_SEND_RST; cnt <= '0; end
                end
                ST_SEND_RST: begin
                    SEND_BYTE    <= 1'b1;
                    BYTE_TO_SEND <= 8'hFF;
                    state        <= ST_WAIT_SENT_RST;
                    cnt          <= '0;
                end
                ST_WAIT_SENT_RST, ST_WAIT_SENT_EN: begin
                    if (BYTE_SENT) begin
                        state <= (state == ST_WAIT_SENT_RST) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
                        cnt   <= '0;
                    end else if (wd_expire) begin
                        state <= ST_STARTUP; cnt <= '0;
                    end
                end
                ST_WAIT_ACK1, ST_WAIT_SELFTEST, ST_WAIT_ID, ST_WAIT_ACK2: begin
                    if (BYTE_READY) begin
                        state <= (rx_err || BYTE_READ != expect_byte) ? ST_STARTUP : init_next;
                        cnt   <= '0;
                    end else if (wd_expire) begin
                        state <= ST_STARTUP; cnt <= '0;
                    end
                end
                ST_SEND_EN: begin
                    SEND_BYTE    <= 1'b1;
                    BYTE_TO_SEND <= 8'hF4;
                    state        <= ST_WAIT_SENT_EN;
                    cnt          <= '0;
                end
                // No timeout here: a stationary mouse sends nothing.
                ST_RX_STATUS: begin
                    if (BYTE_READY && !rx_err && BYTE_READ[3]) begin
                        shadow_status <= BYTE_READ;
                        state         <= ST_RX_DX;
                        cnt           <= '0;
                    end
                end
                ST_RX_DX: begin
                    if (BYTE_READY) begin
                        if (!rx_err) shadow_dx <= BYTE_READ;
                        state <= rx_err ? ST_RX_STATUS : ST_RX_DY;
                        cnt   <= '0;
                    end else if (wd_expire) begin
                        state <= ST_RX_STATUS; cnt <= '0;
                    end
                end
                ST_RX_DY: begin
                    if (BYTE_READY) begin
                        if (!rx_err) shadow_dy <= BYTE_READ;
                        state <= rx_err ? ST_RX_STATUS : ST_IRQ;
                        cnt   <= '0;
                    end else if (wd_expire) begin
                        state <= ST_RX_STATUS; cnt <= '0;
                    end
                end
                ST_IRQ: begin
                    MOUSE_STATUS   <= shadow_status;
                    MOUSE_DX       <= shadow_dx;
                    MOUSE_DY       <= shadow_dy;
                    SEND_INTERRUPT <= 1'b1;
                    state          <= ST_RX_STATUS;
                    cnt            <= '0;
                end
                default: begin
                    state <= ST_STARTUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mouse_master_sm.md
# mouse_master_sm

Sequencer for the PS/2 mouse link. It drives the byte transmitter (send/ack handshake) and the byte receiver (read-enable/byte-ready), and runs the power-up sequence: reset, self-test, ID check and enable data reporting. It then parses 3-byte movement packets into status/dX/dY registers and raises a one-cycle interrupt per packet. It sits between the transmitter/receiver pair and the mouse register/bus interface.

## Interface
Parameters:
- STARTUP_CYCLES, 5_000_000: wait after reset or restart before sending 0xFF (50 ms at 100 MHz).
- TIMEOUT_CYCLES, 100_000_000: watchdog limit per wait state; used only with MOUSE_WATCHDOG_EN.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  reset, asynchronous, active-high.
- SEND_BYTE  out  1  one-cycle request to the transmitter.
- BYTE_TO_SEND  out  8  command byte; held stable from the SEND_BYTE cycle until BYTE_SENT.
- BYTE_SENT  in  1  one-cycle pulse: transmitter finished, device acknowledged.
- READ_ENABLE  out  1  enables the receiver.
- BYTE_READ  in  8  received byte; valid only when BYTE_READY=1.
- BYTE_ERROR_CODE  in  2  valid with BYTE_READY; [0]=parity error, [1]=stop-bit error.
- BYTE_READY  in  1  one-cycle pulse: byte received.
- MOUSE_STATUS  out  8  status byte of the last complete packet.
- MOUSE_DX  out  8  X byte of the last packet (two's complement, sign in STATUS[4]).
- MOUSE_DY  out  8  Y byte of the last packet (sign in STATUS[5]).
- SEND_INTERRUPT  out  1  one-cycle pulse: new packet valid.
- MASTER_STATE  out  4  current state code, for debug.

## Operation
- States (code: behaviour):
  - 0 STARTUP: count to STARTUP_CYCLES-1 -> 1.
  - 1 SEND_RST: SEND_BYTE=1, BYTE_TO_SEND=0xFF -> 2.
  - 2 WAIT_SENT_RST: BYTE_SENT -> 3.
  - 3 WAIT_ACK1: expects 0xFA -> 4.
  - 4 WAIT_SELFTEST: expects 0xAA -> 5.
  - 5 WAIT_ID: expects 0x00 -> 6.
  - 6 SEND_EN: SEND_BYTE=1, BYTE_TO_SEND=0xF4 -> 7.
  - 7 WAIT_SENT_EN: BYTE_SENT -> 8.
  - 8 WAIT_ACK2: expects 0xFA -> 9.
  - 9 RX_STATUS: capture byte into shadow status -> 10.
  - 10 RX_DX: capture into shadow dX -> 11.
  - 11 RX_DY: capture into shadow dY -> 12.
  - 12 IRQ: copy shadows to outputs, SEND_INTERRUPT=1 -> 9.
- States 3-5 and 8: a wrong byte, or BYTE_READY with a nonzero error code, -> 0 (full restart, startup wait included).
- States 9-11: a nonzero error code -> 9 (packet discarded, outputs unchanged).
- State 9: a byte with bit3=0 is a sync error and is discarded; stay in 9.
- READ_ENABLE=1 in states 3-5 and 8-11 only; 0 elsewhere.
- Outputs change only in IRQ; a partial packet never alters MOUSE_STATUS, MOUSE_DX or MOUSE_DY.
- BYTE_READY outside states 3-5 and 8-11 is ignored.

## Timing
- Reset values: state 0; all outputs 0; shadows 0; counters 0.
- RESET mid-sequence: state returns to 0 immediately and asynchronously; an outstanding send is abandoned.
- SEND_BYTE is high exactly one cycle per command. BYTE_TO_SEND is registered and held until the next command.
- A BYTE_READY in state 11 at cycle N gives SEND_INTERRUPT=1 and updated outputs at cycle N+2.
- The STARTUP counter and the watchdog counter clear on every state change; counter width is ceil(log2) of the larger parameter.
- BYTE_SENT and BYTE_READY asserted in the same cycle: only the input relevant to the current state is acted on.

## Configuration
- MOUSE_WATCHDOG_EN defined:
  - Any of states 2-8 held for TIMEOUT_CYCLES -> 0 (restart).
  - State 10 or 11 held for TIMEOUT_CYCLES -> 9 (packet abort).
  - State 9 has no timeout, because the mouse is silent when it is not moving.
- MOUSE_WATCHDOG_EN undefined: no watchdog counter is built; wait states wait indefinitely.

## Test plan
- Nominal init: bench acknowledges 0xFF, then replies 0xFA, 0xAA, 0x00; acknowledges 0xF4, then replies 0xFA -> MASTER_STATE=9, READ_ENABLE=1, exactly two SEND_BYTE pulses (0xFF, 0xF4).
- Packet: 0x28, 0x05, 0xFB after init -> one SEND_INTERRUPT two cycles after the third BYTE_READY; STATUS=0x28, DX=0x05, DY=0xFB.
- Bad self-test: bench replies 0xFC instead of 0xAA -> state 0; after STARTUP_CYCLES, 0xFF is sent again.
- Parity error on the DX byte (error code 01) -> no interrupt; the next clean 0x08, 0x01, 0x02 packet is reported; outputs hold the previous packet until then.
- Sync: byte 0x00 in state 9 is discarded; the following 0x09, 0x10, 0x20 produce STATUS=0x09.
- Watchdog (macro on, TIMEOUT_CYCLES=1000): no BYTE_SENT after 0xFF -> state 0 after 1000 cycles. Same bench with the macro off -> remains in state 2.
